// File: rtl/tx_pulse_scheduler_if.sv
// Bundle between the delay-calculation / sequencing logic (master) and the
// transmit pulse scheduler (slave): table writes, fire/abort control,
// status and the per-channel pulser drive lines.
interface tx_pulse_scheduler_if #(
  parameter int NUM_CHANNELS = 16,
  parameter int DELAY_WIDTH  = 8
);
  localparam int IDX_WIDTH = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic                    delay_wr_en;
  logic [IDX_WIDTH-1:0]    delay_wr_idx;
  logic [DELAY_WIDTH-1:0]  delay_wr_data;
  logic [3:0]              num_cycles;
  logic                    fire;
  logic                    abort;
  logic                    busy;
  logic                    done;
  logic [NUM_CHANNELS-1:0] tx_pos;
  logic [NUM_CHANNELS-1:0] tx_neg;

  modport master (
    output delay_wr_en, delay_wr_idx, delay_wr_data, num_cycles, fire, abort,
    input  busy, done, tx_pos, tx_neg
  );

  modport slave (
    input  delay_wr_en, delay_wr_idx, delay_wr_data, num_cycles, fire, abort,
    output busy, done, tx_pos, tx_neg
  );
endinterface

// File: rtl/tx_pulse_scheduler.sv
// Transmit focusing scheduler: per-channel delay table plus a bipolar
// square-wave burst generator per channel. The FSM and channel generators
// run one cycle ahead of the registered outputs, so a channel with delay d
// shows tx_pos three edges plus d after the edge that samples fire.
module tx_pulse_scheduler #(
  parameter int NUM_CHANNELS = 16,
  parameter int DELAY_WIDTH  = 8,
  parameter int PULSE_HALF   = 2
) (
  input logic clk,
  input logic reset,
  tx_pulse_scheduler_if.slave bus
);
  localparam int IDX_WIDTH  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int HALF_WIDTH = (PULSE_HALF > 1) ? $clog2(PULSE_HALF) : 1;
  localparam logic [HALF_WIDTH-1:0]  HALF_LAST = HALF_WIDTH'(PULSE_HALF - 1);
  localparam logic [DELAY_WIDTH:0]   COUNT_MAX = {1'b1, {DELAY_WIDTH{1'b0}}};
  localparam logic [DELAY_WIDTH:0]   COUNT_ONE = (DELAY_WIDTH+1)'(1);

  typedef enum logic [1:0] {IDLE, ARM, FIRE, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [DELAY_WIDTH:0]    count_reg;
  logic [3:0]              num_reg;
  logic                    abort_hit;
  logic                    table_wr;
  logic                    busy_reg, busy_next;
  logic                    done_reg, done_next;
  logic [NUM_CHANNELS-1:0] tx_pos_reg, tx_pos_next;
  logic [NUM_CHANNELS-1:0] tx_neg_reg, tx_neg_next;
  logic [NUM_CHANNELS-1:0] chan_pos, chan_neg, chan_active, chan_started;

  assign abort_hit = bus.abort && ((state_reg == ARM) || (state_reg == FIRE));
  assign table_wr  = bus.delay_wr_en && (state_reg == IDLE);

  generate
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
      logic [DELAY_WIDTH-1:0] delay_reg;
      logic                   active_reg;
      logic                   pos_phase_reg;
      logic [HALF_WIDTH-1:0]  half_reg;
      logic [3:0]             period_reg;
      logic                   start;

      // Start fires once: the saturating counter passes each value at most once
      assign start            = (state_reg == FIRE) && (count_reg == {1'b0, delay_reg});
      assign chan_started[gi] = count_reg > {1'b0, delay_reg};
      assign chan_active[gi]  = active_reg;
      assign chan_pos[gi]     = active_reg & pos_phase_reg;
      assign chan_neg[gi]     = active_reg & ~pos_phase_reg;

      // Delay entry: writable only while idle, kept across transmits
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          delay_reg <= '0;
        end else if (table_wr && (bus.delay_wr_idx == IDX_WIDTH'(gi))) begin
          delay_reg <= bus.delay_wr_data;
        end
      end

      // Burst generator: positive half then negative half, num_reg periods
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          active_reg    <= 1'b0;
          pos_phase_reg <= 1'b0;
          half_reg      <= '0;
          period_reg    <= '0;
        end else if (abort_hit) begin
          active_reg    <= 1'b0;
          pos_phase_reg <= 1'b0;
          half_reg      <= '0;
          period_reg    <= '0;
        end else if (start) begin
          active_reg    <= 1'b1;
          pos_phase_reg <= 1'b1;
          half_reg      <= '0;
          period_reg    <= '0;
        end else if (active_reg) begin
          if (half_reg == HALF_LAST) begin
            half_reg      <= '0;
            pos_phase_reg <= ~pos_phase_reg;
            if (!pos_phase_reg) begin
              period_reg <= period_reg + 4'd1;
              if (period_reg == (num_reg - 4'd1)) begin
                active_reg <= 1'b0;
              end
            end
          end else begin
            half_reg <= half_reg + HALF_WIDTH'(1);
          end
        end
      end
    end
  endgenerate

  // Delay counter: cleared while arming, saturating count during FIRE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
      num_reg   <= '0;
    end else if (state_reg == ARM) begin
      count_reg <= '0;
      num_reg   <= bus.num_cycles;
    end else if ((state_reg == FIRE) && (count_reg != COUNT_MAX)) begin
      count_reg <= count_reg + COUNT_ONE;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next state and next values of the output registers
  always_comb begin
    state_next  = state_reg;
    busy_next   = 1'b0;
    done_next   = 1'b0;
    tx_pos_next = chan_pos;
    tx_neg_next = chan_neg;
    case (state_reg)
      IDLE: begin
        if (bus.fire) state_next = ARM;
      end
      ARM: begin
        busy_next = 1'b1;
        if (bus.abort || (bus.num_cycles == 4'd0)) state_next = DONE;
        else                                       state_next = FIRE;
      end
      FIRE: begin
        busy_next = 1'b1;
        if (bus.abort || ((&chan_started) && !(|chan_active))) state_next = DONE;
      end
      DONE: begin
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (abort_hit) begin
      tx_pos_next = '0;
      tx_neg_next = '0;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      tx_pos_reg <= '0;
      tx_neg_reg <= '0;
    end else begin
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      tx_pos_reg <= tx_pos_next;
      tx_neg_reg <= tx_neg_next;
    end
  end

  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;
  assign bus.tx_pos = tx_pos_reg;
  assign bus.tx_neg = tx_neg_reg;
endmodule

// File: tb/tb_tx_pulse_scheduler.sv
// Directed bench for tx_pulse_scheduler: expected per-cycle outputs for each
// transmit are derived from the delay table model and pushed to a queue,
// then popped and compared one cycle at a time.
module tb_tx_pulse_scheduler;
  localparam int NC = 16;
  localparam int DW = 8;
  localparam int PH = 2;
  localparam int IW = $clog2(NC);

  typedef struct {
    int            k;
    logic          busy;
    logic          done;
    logic [NC-1:0] pos;
    logic [NC-1:0] neg;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   ncomp = 0;
  int   nfail = 0;
  int   model_delay [NC];
  exp_t sb [$];

  tx_pulse_scheduler_if #(.NUM_CHANNELS(NC), .DELAY_WIDTH(DW)) bus ();

  tx_pulse_scheduler #(.NUM_CHANNELS(NC), .DELAY_WIDTH(DW), .PULSE_HALF(PH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int k, input logic [NC-1:0] obs,
                     input logic [NC-1:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s k=%0d observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  task automatic wr(input int idx, input int data);
    bus.delay_wr_en   = 1'b1;
    bus.delay_wr_idx  = IW'(idx);
    bus.delay_wr_data = DW'(data);
    @(posedge clk); #1;
    bus.delay_wr_en   = 1'b0;
    model_delay[idx]  = data;
  endtask

  // n: periods; inj_k: edge after which a write(ch3=7)+fire is driven;
  // abort_k: edge after which abort is driven; fw_idx/fw_data: write issued
  // in the same cycle as fire (fw_idx < 0 for none).
  task automatic run_tx(input int n, input int inj_k, input int abort_k,
                        input int fw_idx, input int fw_data);
    int   maxd, done_k, last_k, p;
    exp_t e;
    if (fw_idx >= 0) model_delay[fw_idx] = fw_data;
    maxd = 0;
    for (int i = 0; i < NC; i++) if (model_delay[i] > maxd) maxd = model_delay[i];
    done_k = (n == 0) ? 2 : 4 + maxd + 2 * PH * n;
    if (abort_k > 0 && n > 0 && abort_k + 2 < done_k) done_k = abort_k + 2;
    last_k = done_k + 1;
    for (int k = 1; k <= last_k; k++) begin
      e.k = k; e.busy = (k < done_k); e.done = (k == done_k);
      e.pos = '0; e.neg = '0;
      if (n > 0 && !(abort_k > 0 && k > abort_k)) begin
        for (int ch = 0; ch < NC; ch++) begin
          p = k - 3 - model_delay[ch];
          if (p >= 0 && p < 2 * PH * n) begin
            if ((p % (2 * PH)) < PH) e.pos[ch] = 1'b1;
            else                     e.neg[ch] = 1'b1;
          end
        end
      end
      sb.push_back(e);
    end
    bus.num_cycles = 4'(n);
    bus.fire = 1'b1;
    if (fw_idx >= 0) begin
      bus.delay_wr_en = 1'b1; bus.delay_wr_idx = IW'(fw_idx); bus.delay_wr_data = DW'(fw_data);
    end
    @(posedge clk); #1;
    bus.fire = 1'b0; bus.delay_wr_en = 1'b0;
    for (int k = 1; k <= last_k; k++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      chk("tx_pos", e.k, bus.tx_pos, e.pos);
      chk("tx_neg", e.k, bus.tx_neg, e.neg);
      chk("busy", e.k, NC'(bus.busy), NC'(e.busy));
      chk("done", e.k, NC'(bus.done), NC'(e.done));
      chk("overlap", e.k, bus.tx_pos & bus.tx_neg, '0);
      $display("tx n=%0d k=%0d pos=%h neg=%h busy=%b done=%b", n, e.k, bus.tx_pos,
               bus.tx_neg, bus.busy, bus.done);
      bus.delay_wr_en = 1'b0; bus.fire = 1'b0; bus.abort = 1'b0;
      if (k == inj_k) begin
        bus.delay_wr_en = 1'b1; bus.delay_wr_idx = IW'(3); bus.delay_wr_data = DW'(7);
        bus.fire = 1'b1;
      end
      if (k == abort_k) bus.abort = 1'b1;
    end
  endtask

  initial begin
    for (int i = 0; i < NC; i++) model_delay[i] = 0;
    bus.delay_wr_en = 1'b0; bus.delay_wr_idx = '0; bus.delay_wr_data = '0;
    bus.num_cycles = 4'd0; bus.fire = 1'b0; bus.abort = 1'b0;
    reset = 1'b0;
    #12;
    chk("rst_tx_pos", 0, bus.tx_pos, '0);
    chk("rst_tx_neg", 0, bus.tx_neg, '0);
    chk("rst_busy", 0, NC'(bus.busy), '0);
    chk("rst_done", 0, NC'(bus.done), '0);
    $display("reset state pos=%h neg=%h busy=%b done=%b", bus.tx_pos, bus.tx_neg, bus.busy, bus.done);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Basic transmit: ch0=0, ch1=5, others 0, one period
    for (int i = 0; i < NC; i++) wr(i, (i == 1) ? 5 : 0);
    run_tx(1, 0, 0, -1, 0);
    // Zero periods: arm then done, no tx activity
    run_tx(0, 0, 0, -1, 0);
    // Write ch3=7 and re-fire during FIRE: both ignored, then readback
    run_tx(1, 4, 0, -1, 0);
    run_tx(1, 0, 0, -1, 0);
    // Write and fire in the same idle cycle: new ch2 delay is used
    run_tx(2, 0, 0, 2, 3);
    // Abort in the cycle after ch0 first rises
    run_tx(3, 0, 3, -1, 0);

    // Asynchronous reset in the middle of a transmit
    bus.num_cycles = 4'd3; bus.fire = 1'b1;
    @(posedge clk); #1; bus.fire = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    chk("busy_before_reset", 4, NC'(bus.busy), NC'(1'b1));
    chk("pos0_before_reset", 4, NC'(bus.tx_pos[0]), NC'(1'b1));
    reset = 1'b0;
    #1;
    chk("async_tx_pos", 4, bus.tx_pos, '0);
    chk("async_tx_neg", 4, bus.tx_neg, '0);
    chk("async_busy", 4, NC'(bus.busy), '0);
    chk("async_done", 4, NC'(bus.done), '0);
    $display("async reset pos=%h neg=%h busy=%b done=%b", bus.tx_pos, bus.tx_neg, bus.busy, bus.done);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NC; i++) model_delay[i] = 0;
    run_tx(1, 0, 0, -1, 0);

    // Maximum delay on every channel, maximum period count
    for (int i = 0; i < NC; i++) wr(i, 255);
    run_tx(15, 0, 0, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end
endmodule

// File: doc/tx_pulse_scheduler.md
Name: tx_pulse_scheduler

Overview:
- Transmit-side counterpart of the receive delay controller.
- Holds a per-channel transmit focusing delay table and, on a fire command, drives each channel's bipolar pulser with a square-wave burst. Each channel's burst starts after that channel's programmed delay.
- Sits between the delay calculation path, which writes the table, and the per-element pulser drivers.

Parameters:
- NUM_CHANNELS, 16, number of transducer channels.
- DELAY_WIDTH, 8, width of each delay entry in clock cycles (0..2^DELAY_WIDTH-1).
- PULSE_HALF, 2, clock cycles per half-period of the transmit square wave (>=1).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- delay_wr_en  input  1  write strobe for the delay table.
- delay_wr_idx  input  $clog2(NUM_CHANNELS)  channel index to write.
- delay_wr_data  input  DELAY_WIDTH  delay value in cycles.
- num_cycles  input  4  square-wave periods per burst; latched at arm.
- fire  input  1  single-cycle start request.
- abort  input  1  synchronous request to terminate the current transmit.
- busy  output  1  high while arming/transmitting.
- done  output  1  one-cycle completion pulse.
- tx_pos  output  NUM_CHANNELS  positive pulser drive, one bit per channel.
- tx_neg  output  NUM_CHANNELS  negative pulser drive, one bit per channel.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, all delay entries=0, counter=0.
  - busy=0, done=0, tx_pos=0, tx_neg=0.
  - Applies immediately, including mid-transmit.
- All outputs are registered.
- Delay table writes:
  - Accepted on a clock edge only in IDLE when delay_wr_en=1.
  - Ignored in all other states.
  - The table holds its contents across transmits.
- FSM states: IDLE, ARM, FIRE, DONE.
  - IDLE: on fire=1 -> ARM. fire is ignored in every other state.
  - ARM: latch num_cycles, clear counter; busy=1. If the latched num_cycles==0 -> DONE (no tx activity); else -> FIRE.
  - FIRE: busy=1.
    - counter (DELAY_WIDTH+1 bits) increments every cycle and saturates at 2^DELAY_WIDTH.
    - Channel i starts its burst on the edge after a cycle in which counter==delay[i].
    - Exit to DONE on the edge after a cycle in which counter > every delay and no channel is active.
  - DONE: done=1, busy=0, for exactly one cycle, then -> IDLE.
- Timing, with fire sampled at edge E0: ARM at E1; FIRE at E2 with counter=0. For a channel with delay d, tx_pos rises at E(3+d).
- Burst per channel:
  - tx_pos=1 for PULSE_HALF cycles, then tx_neg=1 for PULSE_HALF cycles.
  - This repeats num_cycles times, for a total of 2*PULSE_HALF*num_cycles cycles, then both outputs return to 0.
  - Each channel uses its own phase and period counters.
  - tx_pos[i] & tx_neg[i] must never be 1 in the same cycle.
  - Channels that are not yet started or already finished drive 0/0.
- Abort:
  - abort=1 in ARM or FIRE: next edge forces all tx_pos/tx_neg to 0, clears the channel counters, and goes to DONE. done pulses normally.
  - abort in IDLE or DONE has no effect.
- Boundary conditions:
  - Equal delays on several channels: those channels start in the same cycle.
  - Delay 2^DELAY_WIDTH-1 is valid and is reached before the counter saturates.
  - fire and delay_wr_en in the same IDLE cycle: the write lands and the transmit uses the new value.

Test Plan:
1. PULSE_HALF=2. Write ch0=0, ch1=5, other channels 0. num_cycles=1, fire at E0 -> ch0 tx_pos high E3-E4, tx_neg high E5-E6. ch1 tx_pos high E8-E9, tx_neg high E10-E11, all low from E12. done=1 for the single cycle from E13. busy=1 from E1 to E13.
2. num_cycles=0, fire at E0 -> ARM at E1, done pulse at E2. tx outputs stay 0 throughout. busy=1 only for the E1 cycle.
3. During FIRE, write ch3=7 and pulse fire again -> both ignored. A readback transmit after done shows ch3 keeps its old delay.
4. ch0=0, num_cycles=3, abort asserted in the cycle after ch0 tx_pos first rises -> all tx=0 on the next edge, done pulses the edge after that, no further pulses.
5. reset driven low mid-FIRE, asynchronously between edges -> tx_pos/tx_neg/busy/done drop to 0 immediately. After release, the delay table reads 0 (fire gives all channels starting at E3).
6. All channels delay=255, num_cycles=15 -> every channel starts at E258 and runs 60 cycles. tx_pos & tx_neg is never 1 on any channel in any cycle. done pulses one cycle after all outputs fall.
